// File: rtl/pipe_memory_access.sv
// Memory pipe stage: decodes loads/stores, issues one aligned 32-bit bus access and stalls until it completes.
// Optional bus-timeout abort is compiled in with the MEM_TIMEOUT_EN macro.
module pipe_memory_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stepPipe,
  input  logic [31:0] currentInstruction,
  input  logic [31:0] aluResultData,
  input  logic [31:0] storeData,
  output logic        memoryStall,
  output logic [31:0] memoryAddress,
  output logic [3:0]  memoryByteSelect,
  output logic [31:0] memoryWriteData,
  output logic        memoryWriteEnable,
  output logic        memoryReadEnable,
  input  logic        memoryBusy,
  input  logic [31:0] memoryDataRead,
  output logic [31:0] memoryReadData,
  output logic        addressMisaligned,
  output logic        accessFault
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} memState;

  memState     stateReg, stateNext;
  logic [31:0] addressNext, writeDataNext, readDataNext;
  logic [3:0]  byteSelectNext;
  logic        writeEnableNext, readEnableNext, misalignedNext;
  logic        timedOut;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [3:0]  baseMask;
  logic [6:0]  mask7;
  logic        isLoad, isStore, isMem, misaligned;

  logic        unusedInstr;
  assign unusedInstr = ^{currentInstruction[31:15], currentInstruction[11:7]};

  assign opcode  = currentInstruction[6:0];
  assign funct3  = currentInstruction[14:12];
  assign isLoad  = (opcode == 7'b0000011);
  assign isStore = (opcode == 7'b0100011);
  assign isMem   = isLoad | isStore;

  always_comb begin
    baseMask = 4'b0000;
    case (funct3[1:0])
      2'b00:   baseMask = 4'b0001;
      2'b01:   baseMask = 4'b0011;
      2'b10:   baseMask = (funct3 == 3'b010) ? 4'b1111 : 4'b0000;
      default: baseMask = 4'b0000;
    endcase
  end

  // Lanes pushed past bit 3 mean the access crosses the word boundary.
  assign mask7       = {3'b000, baseMask} << aluResultData[1:0];
  assign misaligned  = |mask7[6:4];
  assign memoryStall = (stateReg == ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] timeoutCount;

  assign timedOut = (stateReg == ACCESS) && memoryBusy &&
                    (32'(timeoutCount) + 32'd1 == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst || stateReg != ACCESS) timeoutCount <= '0;
    else if (memoryBusy)           timeoutCount <= timeoutCount + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                accessFault <= 1'b0;
    else if (stateReg != ACCESS && stepPipe) accessFault <= 1'b0;
    else if (timedOut)                      accessFault <= 1'b1;
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = |TIMEOUT_CYCLES;
  assign timedOut      = 1'b0;
  assign accessFault   = 1'b0;
`endif

  always_comb begin
    stateNext       = stateReg;
    addressNext     = memoryAddress;
    byteSelectNext  = memoryByteSelect;
    writeDataNext   = memoryWriteData;
    writeEnableNext = memoryWriteEnable;
    readEnableNext  = memoryReadEnable;
    readDataNext    = memoryReadData;
    misalignedNext  = addressMisaligned;
    case (stateReg)
      IDLE, DONE: begin
        if (stepPipe) begin
          if (isMem && baseMask != 4'b0000 && !misaligned) begin
            stateNext       = ACCESS;
            addressNext     = {aluResultData[31:2], 2'b00};
            byteSelectNext  = mask7[3:0];
            writeDataNext   = storeData << {aluResultData[1:0], 3'b000};
            writeEnableNext = isStore;
            readEnableNext  = isLoad;
            misalignedNext  = 1'b0;
          end else if (isMem && misaligned) begin
            stateNext      = DONE;
            misalignedNext = 1'b1;
            readDataNext   = 32'h0;
          end else begin
            stateNext      = DONE;
            misalignedNext = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (!memoryBusy) begin
          stateNext       = DONE;
          writeEnableNext = 1'b0;
          readEnableNext  = 1'b0;
          if (memoryReadEnable) readDataNext = memoryDataRead;
        end else if (timedOut) begin
          stateNext       = DONE;
          writeEnableNext = 1'b0;
          readEnableNext  = 1'b0;
          readDataNext    = 32'h0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg          <= IDLE;
      memoryAddress     <= 32'h0;
      memoryByteSelect  <= 4'h0;
      memoryWriteData   <= 32'h0;
      memoryWriteEnable <= 1'b0;
      memoryReadEnable  <= 1'b0;
      memoryReadData    <= 32'h0;
      addressMisaligned <= 1'b0;
    end else begin
      stateReg          <= stateNext;
      memoryAddress     <= addressNext;
      memoryByteSelect  <= byteSelectNext;
      memoryWriteData   <= writeDataNext;
      memoryWriteEnable <= writeEnableNext;
      memoryReadEnable  <= readEnableNext;
      memoryReadData    <= readDataNext;
      addressMisaligned <= misalignedNext;
    end
  end

endmodule
